// File: rtl/alsu_req_arbiter_if.sv
// Requester channel between one client and the ALSU arbiter.
// One valid/ready command channel (packed ALSU command) and one
// valid/ready response channel (captured ALSU out plus error flag).
//   cmd_valid / cmd_ready / cmd[15:0]   client -> arbiter command
//   rsp_valid / rsp_ready               arbiter -> client response handshake
//   rsp_data[5:0] / rsp_err             captured ALSU out, 1 = leds were nonzero
// cmd packing: {bypass_B,bypass_A,red_op_B,red_op_A,direction,serial_in,cin,opcode[2:0],B[2:0],A[2:0]}
interface alsu_req_arbiter_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [5:0]  rsp_data;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alsu_req_arbiter.sv
// Shares one ALSU between two requesters. A command is granted in IDLE,
// driven onto the ALSU inputs for exactly one cycle, the ALSU pipeline
// latency is waited out with a down-counter, and the result is held on the
// owner's response channel until it is consumed. One command in flight.
//
// Ports
//   CLK, RST_n            clock (rising edge), async active-low reset
//   r0, r1                requester channels (slave side)
//   alsu_*  (out)         ALSU operand/control inputs, all zero except in ISSUE
//   alsu_out, alsu_leds   ALSU result and error leds
//   busy                  high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | arbitrate, accept one command
// ISSUE | latched command on the ALSU inputs (single cycle)
// WAIT  | count down ALSU latency, capture result on terminal count
// RESP  | hold response for the owner until rsp_ready
module alsu_req_arbiter #(
    parameter int    ALSU_LATENCY = 2,
    parameter string ARB_MODE     = "RR"
) (
    input  logic              CLK,
    input  logic              RST_n,
    alsu_req_arbiter_if.slave r0,
    alsu_req_arbiter_if.slave r1,
    output logic [2:0]        alsu_A,
    output logic [2:0]        alsu_B,
    output logic [2:0]        alsu_opcode,
    output logic              alsu_cin,
    output logic              alsu_serial_in,
    output logic              alsu_direction,
    output logic              alsu_red_op_A,
    output logic              alsu_red_op_B,
    output logic              alsu_bypass_A,
    output logic              alsu_bypass_B,
    input  logic [5:0]        alsu_out,
    input  logic [15:0]       alsu_leds,
    output logic              busy
);

    localparam bit RR_MODE = (ARB_MODE == "RR");

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [15:0] issue_q, issue_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [5:0]  data_q, data_d;
    logic        err_q, err_d;
    logic        grant0, grant1;
    logic        own_rsp_ready;

    // r1 wins when alone, or on a tie in round-robin mode when r0 had the last grant.
    always_comb begin
        grant1 = r1.cmd_valid && (!r0.cmd_valid || (RR_MODE && !last_grant_q));
        grant0 = r0.cmd_valid && !grant1;
    end

    assign r0.cmd_ready = (state_q == IDLE) && grant0;
    assign r1.cmd_ready = (state_q == IDLE) && grant1;

    always_comb begin
        state_d       = state_q;
        issue_d       = '0;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        err_d         = err_q;
        own_rsp_ready = owner_q ? r1.rsp_ready : r0.rsp_ready;

        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    // issue_q is loaded only on accept, so the ALSU sees the
                    // command for the single ISSUE cycle and a NOP otherwise.
                    issue_d      = grant1 ? r1.cmd : r0.cmd;
                    owner_d      = grant1;
                    last_grant_d = grant1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 3'(ALSU_LATENCY);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    data_d  = alsu_out;
                    err_d   = |alsu_leds;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (own_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q      <= IDLE;
            issue_q      <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_q      <= issue_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            err_q        <= err_d;
        end
    end

    assign {alsu_bypass_B, alsu_bypass_A, alsu_red_op_B, alsu_red_op_A,
            alsu_direction, alsu_serial_in, alsu_cin, alsu_opcode,
            alsu_B, alsu_A} = issue_q;

    assign r0.rsp_valid = (state_q == RESP) && !owner_q;
    assign r1.rsp_valid = (state_q == RESP) &&  owner_q;
    assign r0.rsp_data  = data_q;
    assign r1.rsp_data  = data_q;
    assign r0.rsp_err   = err_q;
    assign r1.rsp_err   = err_q;

    assign busy = (state_q != IDLE);

endmodule
